// File: rtl/calc_pkg.sv
// Shared encodings for the parameter calculator: operation codes, FSM states
// and the iterative-unit mode select.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

    // Mode select for the shared multiply/divide iteration unit.
    localparam logic ITER_MUL = 1'b0;
    localparam logic ITER_DIV = 1'b1;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative unsigned multiply / divide unit: shift-add multiplier and
// restoring divider, both retiring exactly one bit per clock over W clocks.
// The unit loads on start_i and raises done_o on the clock of its last step;
// res_o/rem_o present the value that step produces, so the caller can
// capture the final answer on the same edge.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start_i,
    input  logic           mode_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] res_o,
    output logic [W-1:0]   rem_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // hi holds the partial product (mul) or partial remainder (div);
    // lo holds the multiplier being shifted out (mul) or dividend/quotient (div).
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          mode_q, mode_d;

    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W-1:0]  div_diff;
    logic          div_fit;
    logic [W-1:0]  step_hi;
    logic [W-1:0]  step_lo;
    logic          last_step;

    // One iteration of the selected algorithm, plus load/advance control.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(W+1){1'b0}});
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift[W-1:0] - dvs_q;
        div_fit   = (div_shift >= {1'b0, dvs_q});
        last_step = run_q && (cnt_q == CW'(W-1));

        if (mode_q == ITER_MUL) begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end else if (div_fit) begin
            step_hi = div_diff;
            step_lo = {lo_q[W-2:0], 1'b1};
        end else begin
            step_hi = div_shift[W-1:0];
            step_lo = {lo_q[W-2:0], 1'b0};
        end

        hi_d   = hi_q;
        lo_d   = lo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        mode_d = mode_q;

        if (start_i) begin
            hi_d   = '0;
            lo_d   = a_i;
            dvs_d  = b_i;
            cnt_d  = '0;
            run_d  = 1'b1;
            mode_d = mode_i;
        end else if (run_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
                run_d = 1'b0;
            end
        end
    end

    // Iteration state registers; Reset discards any partial operation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            mode_q <= ITER_MUL;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            mode_q <= mode_d;
        end
    end

    assign done_o = last_step;
    assign res_o  = {step_hi, step_lo};
    assign rem_o  = step_hi;

endmodule

// File: rtl/param_calculator.sv
// Parameter calculator: add/sub in one execute cycle, mul/div through the
// iterative unit in W cycles, with Done/Err handshake closed by Ack.
// Optional build macro CALC_SIGNED_EN switches operands and results to
// two's complement; the default build is purely unsigned.
module param_calculator
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [W-1:0]   A_in,
    input  logic [W-1:0]   B_in,
    input  logic [1:0]     Op,
    input  logic           Ack,
    output logic           Busy,
    output logic           Done,
    output logic           Err,
    output logic [2*W-1:0] Result,
    output logic [W-1:0]   Rem,
    output logic           Flag
);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    op_e            op_q, op_d;
    logic [2*W-1:0] result_q, result_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           flag_q, flag_d;

    op_e            op_in;
    logic           div_zero;
    logic           iter_start;
    logic           iter_mode;
    logic           iter_done;
    logic [W-1:0]   iter_a;
    logic [W-1:0]   iter_b;
    logic [2*W-1:0] iter_res;
    logic [W-1:0]   iter_rem;
    logic [W:0]     sum_w;
    logic [W:0]     diff_w;

    assign op_in      = op_e'(Op);
    assign div_zero   = (B_in == '0);
    assign iter_start = (state_q == IDLE) && Start &&
                        ((op_in == OP_MUL) || ((op_in == OP_DIV) && !div_zero));
    assign iter_mode  = (op_in == OP_DIV) ? ITER_DIV : ITER_MUL;

`ifdef CALC_SIGNED_EN
    // The iterative unit works on magnitudes; signs are restored on capture.
    assign iter_a = A_in[W-1] ? -A_in : A_in;
    assign iter_b = B_in[W-1] ? -B_in : B_in;

    logic           neg_res;
    logic [2*W-1:0] mul_s;
    logic [W-1:0]   quo_s;
    logic [W-1:0]   rem_s;
    logic           min_by_neg1;

    // Sign restoration of the magnitude results.
    always_comb begin
        neg_res     = a_q[W-1] ^ b_q[W-1];
        mul_s       = neg_res ? -iter_res : iter_res;
        quo_s       = neg_res ? -iter_res[W-1:0] : iter_res[W-1:0];
        rem_s       = a_q[W-1] ? -iter_rem : iter_rem;
        min_by_neg1 = (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1);
    end
`else
    assign iter_a = A_in;
    assign iter_b = B_in;
`endif

    calc_iter_unit #(
        .W (W)
    ) u_iter (
        .Clk     (Clk),
        .Reset   (Reset),
        .start_i (iter_start),
        .mode_i  (iter_mode),
        .a_i     (iter_a),
        .b_i     (iter_b),
        .done_o  (iter_done),
        .res_o   (iter_res),
        .rem_o   (iter_rem)
    );

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; Ack takes priority over Start in DONE/ERR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (op_in)
                        OP_ADD, OP_SUB: state_d = EXEC;
                        OP_MUL:         state_d = MUL;
                        default:        state_d = div_zero ? ERR : DIV;
                    endcase
                end
            end
            EXEC:      state_d = DONE;
            MUL, DIV:  if (iter_done) state_d = DONE;
            DONE, ERR: if (Ack) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        Busy = (state_q == EXEC) || (state_q == MUL) || (state_q == DIV);
        Done = (state_q == DONE);
        Err  = (state_q == ERR);
    end

    // Operand capture and result formation for each operation.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        rem_d    = rem_q;
        flag_d   = flag_q;

`ifdef CALC_SIGNED_EN
        sum_w  = {a_q[W-1], a_q} + {b_q[W-1], b_q};
        diff_w = {a_q[W-1], a_q} - {b_q[W-1], b_q};
`else
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d      = A_in;
                    b_d      = B_in;
                    op_d     = op_in;
                    result_d = '0;
                    rem_d    = '0;
                    flag_d   = (op_in == OP_DIV) && div_zero;
                end
            end
            EXEC: begin
`ifdef CALC_SIGNED_EN
                if (op_q == OP_ADD) begin
                    result_d = {{(W-1){sum_w[W]}}, sum_w};
                    flag_d   = sum_w[W] ^ sum_w[W-1];
                end else begin
                    result_d = {{(W-1){diff_w[W]}}, diff_w};
                    flag_d   = diff_w[W] ^ diff_w[W-1];
                end
`else
                if (op_q == OP_ADD) begin
                    result_d = {{(W-1){1'b0}}, sum_w};
                    flag_d   = sum_w[W];
                end else begin
                    result_d = {{W{1'b0}}, diff_w[W-1:0]};
                    flag_d   = diff_w[W];
                end
`endif
            end
            MUL: begin
                if (iter_done) begin
`ifdef CALC_SIGNED_EN
                    result_d = mul_s;
                    flag_d   = !((&mul_s[2*W-1:W-1]) || !(|mul_s[2*W-1:W-1]));
`else
                    result_d = iter_res;
                    flag_d   = |iter_res[2*W-1:W];
`endif
                end
            end
            DIV: begin
                if (iter_done) begin
`ifdef CALC_SIGNED_EN
                    result_d = {{W{quo_s[W-1]}}, quo_s};
                    rem_d    = rem_s;
                    flag_d   = (|rem_s) || min_by_neg1;
`else
                    result_d = {{W{1'b0}}, iter_res[W-1:0]};
                    rem_d    = iter_rem;
                    flag_d   = |iter_rem;
`endif
                end
            end
            default: ;
        endcase
    end

    // Operand and result registers; cleared by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            rem_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            flag_q   <= flag_d;
        end
    end

    assign Result = result_q;
    assign Rem    = rem_q;
    assign Flag   = flag_q;

endmodule

// File: tb/tb_param_calculator.sv
// Self-checking bench for param_calculator (default unsigned build, W=16):
// directed corner cases, a mid-multiply reset, then randomized operations
// compared against an arithmetic reference model.
module tb_param_calculator;

    localparam int W = 16;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Start;
    logic           Ack;
    logic [W-1:0]   A_in;
    logic [W-1:0]   B_in;
    logic [1:0]     Op;
    logic           Busy;
    logic           Done;
    logic           Err;
    logic [2*W-1:0] Result;
    logic [W-1:0]   Rem;
    logic           Flag;

    int n_total = 0;
    int n_bad   = 0;

    always #5 Clk = ~Clk;

    param_calculator #(.W(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .A_in   (A_in),
        .B_in   (B_in),
        .Op     (Op),
        .Ack    (Ack),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err),
        .Result (Result),
        .Rem    (Rem),
        .Flag   (Flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    task automatic model(input int op, input longint a, input longint b,
                         output longint res, output longint rem, output bit flag,
                         output bit err, output int lat, output int busy);
        longint lim;
        lim  = longint'(1) << W;
        rem  = 0;
        err  = 0;
        case (op)
            0: begin res = a + b; flag = (res >= lim); lat = 2; busy = 1; end
            1: begin res = (a - b + lim) % lim; flag = (a < b); lat = 2; busy = 1; end
            2: begin res = a * b; flag = (res >= lim); lat = W + 1; busy = W; end
            default: begin
                if (b == 0) begin
                    res = 0; flag = 1; err = 1; lat = 1; busy = 0;
                end else begin
                    res = a / b; rem = a % b; flag = (rem != 0); lat = W + 1; busy = W;
                end
            end
        endcase
    endtask

    // Launch one operation from IDLE (called at a falling edge), follow it to
    // DONE/ERR while throwing ignored Start/Ack traffic at it, then Ack it.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        longint e_res, e_rem;
        bit     e_flag, e_err;
        int     e_lat, e_busy;
        int     k, nb, nhold;
        bit     seen;
        model(int'(op), longint'(a), longint'(b), e_res, e_rem, e_flag, e_err, e_lat, e_busy);
        Op = op; A_in = a; B_in = b; Start = 1'b1; Ack = 1'b0;
        k = 0; nb = 0; seen = 0;
        while (!seen && k < 60) begin
            @(negedge Clk);
            k++;
            if (Busy) nb++;
            if (k == 1 && !e_err) check({tag, "/cleared"}, Result, 0);
            if (Done || Err) begin
                seen = 1;
            end else begin
                Start = 1'($urandom);
                A_in  = W'($urandom);
                B_in  = W'($urandom);
                Op    = 2'($urandom);
                Ack   = 1'($urandom);
            end
        end
        check({tag, "/latency"}, k, e_lat);
        check({tag, "/busy_cycles"}, nb, e_busy);
        check({tag, "/done"}, Done, !e_err);
        check({tag, "/err"}, Err, e_err);
        check({tag, "/result"}, Result, e_res);
        check({tag, "/rem"}, Rem, e_rem);
        check({tag, "/flag"}, Flag, e_flag);
        nhold = $urandom_range(0, 2);
        for (int i = 0; i < nhold; i++) begin
            Ack = 1'b0; Start = 1'($urandom); A_in = W'($urandom); Op = 2'($urandom);
            @(negedge Clk);
            check({tag, "/hold_state"}, {Done, Err}, {!e_err, e_err});
            check({tag, "/hold_result"}, Result, e_res);
        end
        Ack = 1'b1; Start = 1'($urandom);
        @(negedge Clk);
        Ack = 1'b0; Start = 1'b0;
        check({tag, "/ack_idle"}, {Busy, Done, Err}, 3'b000);
        check({tag, "/after_ack_result"}, Result, e_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        Reset = 1'b1; Start = 1'b0; Ack = 1'b0; A_in = '0; B_in = '0; Op = 2'b00;
        #2;
        check("reset/flags", {Busy, Done, Err, Flag}, 4'b0000);
        check("reset/result", Result, 0);
        check("reset/rem", Rem, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        run_op(2'b00, 16'hFFFF, 16'h0001, "add_carry");
        run_op(2'b01, 16'd5, 16'd7, "sub_borrow");
        run_op(2'b10, 16'h0100, 16'h0100, "mul_ovf");
        run_op(2'b11, 16'd100, 16'd7, "div_100_7");
        run_op(2'b11, 16'd5, 16'd0, "div_zero");
        run_op(2'b10, 16'hFFFF, 16'hFFFF, "mul_max");
        run_op(2'b11, 16'hFFFF, 16'h0001, "div_by_one");
        run_op(2'b11, 16'd3, 16'd5, "div_small");
        run_op(2'b00, 16'd0, 16'd0, "add_zero");
        run_op(2'b01, 16'd0, 16'd0, "sub_zero");

        // Reset in the middle of a multiply, then a normal operation.
        Op = 2'b10; A_in = 16'h1234; B_in = 16'h0056; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (7) @(negedge Clk);
        check("midmul/busy_before", Busy, 1);
        Reset = 1'b1;
        #1;
        check("midmul_reset/flags", {Busy, Done, Err, Flag}, 4'b0000);
        check("midmul_reset/result", Result, 0);
        check("midmul_reset/rem", Rem, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_op(2'b10, 16'h00FF, 16'h0101, "after_reset_mul");

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
